// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// One shift-add / restoring shift-subtract step per clock. Magnitudes are
// processed unsigned and the sign is fixed up in the FINISH cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic [WIDTH-1:0] write_value,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;

  // Operation context captured at launch
  logic             is_div_p0;
  logic             neg_prod_p0;
  logic             neg_quot_p0;
  logic             neg_rem_p0;
  logic             dbz_p0;
  logic [WIDTH-1:0] a_raw_p0;
  logic [WIDTH-1:0] b_mag_p0;

  // Iteration registers: r holds partial product high half / partial remainder,
  // q holds multiplier being shifted out / dividend shifted out, quotient in
  logic [WIDTH-1:0] r_p1;
  logic [WIDTH-1:0] q_p1;

  logic             launch;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] step_r;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  // Absolute value of a two's complement operand when the op is signed
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    logic [WIDTH-1:0] u;
    u = v;
    return (is_signed && v[WIDTH-1]) ? -u : u;
  endfunction

  // Conditional two's complement negation, single width
  function automatic logic [WIDTH-1:0] fix_sign_w(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? -v : v;
  endfunction

  // Conditional two's complement negation, double width product
  function automatic logic [2*WIDTH-1:0] fix_sign_2w(input logic [2*WIDTH-1:0] v,
                                                     input logic neg);
    return neg ? -v : v;
  endfunction

  assign launch = (state == IDLE) && start;

  // One iteration step for the currently latched operation
  always_comb begin
    mul_sum  = {1'b0, r_p1} + (q_p1[0] ? {1'b0, b_mag_p0} : '0);
    div_sh   = {r_p1, q_p1[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, b_mag_p0});
    div_diff = div_sh[WIDTH-1:0] - b_mag_p0;
    if (is_div_p0) begin
      step_r = div_ge ? div_diff : div_sh[WIDTH-1:0];
      step_q = {q_p1[WIDTH-2:0], div_ge};
    end else begin
      step_r = mul_sum[WIDTH:1];
      step_q = {mul_sum[0], q_p1[WIDTH-1:1]};
    end
  end

  // Final HI/LO values with sign correction and divide-by-zero override
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (dbz_p0) begin
      res_hi = a_raw_p0;
      res_lo = '1;
    end else if (is_div_p0) begin
      res_hi = fix_sign_w(r_p1, neg_rem_p0);
      res_lo = fix_sign_w(q_p1, neg_quot_p0);
    end else begin
      {res_hi, res_lo} = fix_sign_2w({r_p1, q_p1}, neg_prod_p0);
    end
  end

  // ---- stage p0: capture operation context at launch (data, no reset) ----
  always_ff @(posedge clock) begin
    if (launch) begin
      is_div_p0   <= op[1];
      neg_prod_p0 <= ~op[0] & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
      neg_quot_p0 <= ~op[0] & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
      neg_rem_p0  <= ~op[0] & operand_a[WIDTH-1];
      dbz_p0      <= op[1] && (operand_b == '0);
      a_raw_p0    <= operand_a;
      b_mag_p0    <= op[1] ? magnitude($signed(operand_b), ~op[0])
                           : magnitude($signed(operand_a), ~op[0]);
    end
  end

  // ---- stage p1: iterative shift-add / shift-subtract (data, no reset) ----
  always_ff @(posedge clock) begin
    if (launch) begin
      r_p1 <= '0;
      q_p1 <= op[1] ? magnitude($signed(operand_a), ~op[0])
                    : magnitude($signed(operand_b), ~op[0]);
    end else if (state == RUN) begin
      r_p1 <= step_r;
      q_p1 <= step_q;
    end
  end

  // Control FSM with registered status outputs and the architectural HI/LO
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_write) hi <= write_value;
          if (lo_write) lo <= write_value;
          if (start) begin
            state <= RUN;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= FINISH;
        end
        FINISH: begin
          hi          <= res_hi;
          lo          <= res_lo;
          done        <= 1'b1;
          div_by_zero <= dbz_p0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard testbench for mult_div_unit: expected HI/LO/flag and completion
// edge are queued at issue time and checked by an independent done monitor.
module tb_mult_div_unit;

  localparam int W   = 32;
  localparam int LAT = 33;

  logic          clock;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic          hi_write;
  logic          lo_write;
  logic [W-1:0]  write_value;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           edge_n;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .hi_write(hi_write), .lo_write(lo_write), .write_value(write_value),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    longint      sa, sb, sq, sr;
    logic [63:0] p, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    z  = 1'b0;
    case (o)
      2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
      default: begin
        if (b == 0) begin
          h = a; l = '1; z = 1'b1;
        end else if (o == 2'b10) begin
          sq = sa / sb; sr = sa % sb;
          p = sq; l = p[31:0];
          p = sr; h = p[31:0];
        end else begin
          p = ua / ub; l = p[31:0];
          p = ua % ub; h = p[31:0];
        end
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (!reset) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("hi", 64'(hi), 64'(e.hi));
          chk("lo", 64'(lo), 64'(e.lo));
          chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          chk("done_edge", 64'(cyc), 64'(e.edge_n));
        end
      end else if (div_by_zero) begin
        chk("dbz_without_done", 64'(div_by_zero), 64'(0));
      end
    end
  end

  // Drive one launch; called between clock edges, returns #1 after edge E0
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input bit mt);
    exp_t e;
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    if (mt) begin hi_write = 1'b1; write_value = 32'h1357_2468; end
    if (push) begin
      model(o, a, b, e.hi, e.lo, e.dbz);
      e.edge_n = cyc + 1 + LAT;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    start = 1'b0; hi_write = 1'b0;
    op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
  endtask

  // Launch, watch busy/hold behaviour, optionally inject ignored start/MTHI/MTLO
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit inject, input bit mt);
    logic [W-1:0] h0, l0;
    int  n;
    bit  got;
    h0 = '0; l0 = '0; n = 0; got = 0;
    issue(o, a, b, 1'b1, mt);
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clock);
      if (k == 0) begin
        h0 = hi; l0 = lo;
        if (mt) chk("mthi_with_start", 64'(hi), 64'h1357_2468);
      end
      if (done) begin
        got = 1;
      end else begin
        if (busy) n++;
        if (k > 0) begin
          chk("hi_hold", 64'(hi), 64'(h0));
          chk("lo_hold", 64'(lo), 64'(l0));
        end
        if (inject && k == 5) begin
          start = 1'b1; hi_write = 1'b1; lo_write = 1'b1;
          write_value = $urandom; operand_a = $urandom; operand_b = $urandom;
        end
        if (inject && k == 6) begin
          start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
        end
      end
    end
    if (!got) begin
      chk("done_timeout", 64'(0), 64'(1));
    end else begin
      chk("busy_cycles", 64'(n), 64'(LAT));
      chk("busy_at_done", 64'(busy), 64'(0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    logic [1:0]   o;
    int           seen;
    reset = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    hi_write = 1'b0; lo_write = 1'b0; write_value = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_dbz",  64'(div_by_zero), 64'(0));
    chk("reset_hi",   64'(hi), 64'(0));
    chk("reset_lo",   64'(lo), 64'(0));

    // MTHI / MTLO in IDLE
    hi_write = 1'b1; write_value = 32'hA5A5_A5A5;
    @(posedge clock); #1 hi_write = 1'b0;
    chk("mthi_idle", 64'(hi), 64'hA5A5_A5A5);
    chk("mthi_no_done", 64'(done), 64'(0));
    lo_write = 1'b1; write_value = 32'h5A5A_0F0F;
    @(posedge clock); #1 lo_write = 1'b0;
    chk("mtlo_idle", 64'(lo), 64'h5A5A_0F0F);
    chk("mthi_kept", 64'(hi), 64'hA5A5_A5A5);

    // Directed operations
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b1);
    run_op(2'b11, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // Randomized back-to-back operations
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 7) == 0) b = '0;
      run_op(o, a, b, (i % 5) == 0, (i % 7) == 3);
    end

    repeat (40) @(negedge clock);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    // Make HI/LO nonzero, then reset in the middle of MULTU 5*7
    hi_write = 1'b1; lo_write = 1'b1; write_value = 32'hDEAD_BEEF;
    @(posedge clock); #1 hi_write = 1'b0; lo_write = 1'b0;
    issue(2'b01, 32'd5, 32'd7, 1'b0, 1'b0);
    repeat (9) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    chk("midreset_busy", 64'(busy), 64'(0));
    chk("midreset_hi", 64'(hi), 64'(0));
    chk("midreset_lo", 64'(lo), 64'(0));
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done) seen++;
    end
    chk("midreset_no_done", 64'(seen), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
